// File: rtl/prog_loader.sv
// prog_loader: byte-serial loader that packs host bytes little-endian into 32-bit words for the instruction RAM.
// Latency: a byte is captured SYNC_STAGES+2 clk edges after its strobe rises; the word write follows one cycle after byte 3.
// Backpressure: none; the host paces strobes, and one edge can queue (pending) while a WRITE cycle is in progress.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   load_en              asynchronous level, 1 = load mode (2-flop synchronised)
//   byte_in, byte_strb   program byte and its asynchronous strobe (rising edge = one byte)
//   mem_we/addr/wdata    one-cycle RAM write port
//   word_cnt             words written since load start (saturates at DEPTH)
//   load_done, cpu_run   loader finished / core allowed to run
//   checksum             mod-256 sum of captured bytes when LOADER_CHECKSUM_EN is defined, else 0
module prog_loader #(
  parameter int DEPTH       = 32,
  parameter int ADDR_W      = 7,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [7:0]        byte_in,
  input  logic              byte_strb,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W-1:0] word_cnt,
  output logic              load_done,
  output logic              cpu_run,
  output logic [7:0]        checksum
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic                   ld_s1_q, ld_s1_d;
  logic                   ld_s2_q, ld_s2_d;
  logic                   ld_prev_q, ld_prev_d;
  logic [SYNC_STAGES-1:0] strb_sync_q, strb_sync_d;
  logic                   strb_prev_q, strb_prev_d;
  logic                   pending_q, pending_d;
  logic [1:0]             byte_idx_q, byte_idx_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [ADDR_W-1:0]      cnt_q, cnt_d;

  logic load_en_sync;
  logic ld_rise;
  logic strb_rise;
  logic capture;
  logic start_load;

  assign load_en_sync = ld_s2_q;
  assign ld_rise      = ld_s2_q & ~ld_prev_q;
  assign strb_rise    = strb_sync_q[SYNC_STAGES-1] & ~strb_prev_q;

  always_comb begin
    state_d     = state_q;
    ld_s1_d     = load_en;
    ld_s2_d     = ld_s1_q;
    ld_prev_d   = ld_s2_q;
    strb_sync_d = {strb_sync_q[SYNC_STAGES-2:0], byte_strb};
    strb_prev_d = strb_sync_q[SYNC_STAGES-1];
    pending_d   = pending_q | strb_rise;
    byte_idx_d  = byte_idx_q;
    wdata_d     = wdata_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    capture     = 1'b0;
    start_load  = 1'b0;

    case (state_q)
      S_IDLE: begin
        pending_d = 1'b0;
        if (load_en_sync) start_load = 1'b1;
      end
      S_LOAD: begin
        // Dropping load_en wins over a same-cycle capture: the partial word is discarded anyway.
        if (!load_en_sync) begin
          state_d = S_DONE;
        end else if (pending_q) begin
          capture   = 1'b1;
          pending_d = strb_rise;
        end
      end
      S_WRITE: begin
        // pending_d keeps any edge seen now; it is consumed in the next LOAD cycle.
        byte_idx_d = 2'd0;
        if (cnt_q != ADDR_W'(DEPTH)) cnt_d = cnt_q + 1'b1;
        if (addr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        pending_d = 1'b0;
        // Only a fresh 0->1 of load_en restarts; a level left high after auto-finish does not.
        if (ld_rise) start_load = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      case (byte_idx_q)
        2'd0:    wdata_d[7:0]   = byte_in;
        2'd1:    wdata_d[15:8]  = byte_in;
        2'd2:    wdata_d[23:16] = byte_in;
        default: wdata_d[31:24] = byte_in;
      endcase
      byte_idx_d = byte_idx_q + 2'd1;
      if (byte_idx_q == 2'd3) state_d = S_WRITE;
    end

    if (start_load) begin
      state_d    = S_LOAD;
      addr_d     = '0;
      cnt_d      = '0;
      byte_idx_d = 2'd0;
      wdata_d    = 32'h0;
      pending_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ld_s1_q     <= 1'b0;
      ld_s2_q     <= 1'b0;
      ld_prev_q   <= 1'b0;
      strb_sync_q <= '0;
      strb_prev_q <= 1'b0;
      pending_q   <= 1'b0;
      byte_idx_q  <= 2'd0;
      wdata_q     <= 32'h0;
      addr_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      ld_s1_q     <= ld_s1_d;
      ld_s2_q     <= ld_s2_d;
      ld_prev_q   <= ld_prev_d;
      strb_sync_q <= strb_sync_d;
      strb_prev_q <= strb_prev_d;
      pending_q   <= pending_d;
      byte_idx_q  <= byte_idx_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (capture)    csum_d = csum_q + byte_in;
    if (start_load) csum_d = 8'h00;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) csum_q <= 8'h00;
    else        csum_q <= csum_d;
  end

  assign checksum = csum_q;
`else
  assign checksum = 8'h00;
`endif

  assign mem_we    = (state_q == S_WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign word_cnt  = cnt_q;
  assign load_done = (state_q == S_DONE);
  assign cpu_run   = ((state_q == S_IDLE) || (state_q == S_DONE)) && !load_en_sync;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench for prog_loader (table of single-word loads plus multi-cycle sequences).
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_en;
  logic [7:0]  byte_in;
  logic        byte_strb;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [6:0]  word_cnt;
  logic        load_done;
  logic        cpu_run;
  logic [7:0]  checksum;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic [6:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  prog_loader #(.DEPTH(32), .ADDR_W(7), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .byte_in(byte_in), .byte_strb(byte_strb),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .word_cnt(word_cnt),
    .load_done(load_done), .cpu_run(cpu_run), .checksum(checksum)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  end

  typedef struct {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp_data;
    logic [6:0]  exp_addr;
    logic [6:0]  exp_cnt;
    logic [7:0]  exp_csum;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    byte_in   = b;
    byte_strb = 1'b1;
    repeat (6) @(negedge clk);
    byte_strb = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base;
    logic [31:0] expw;
    logic [7:0]  bv;

    tbl[0] = '{8'h13, 8'h00, 8'h00, 8'h00, 32'h00000013, 7'd0, 7'd1, 8'h13};
    tbl[1] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 32'hDDCCBBAA, 7'd1, 7'd2, 8'h21};
    tbl[2] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201, 7'd2, 7'd3, 8'h2B};
    tbl[3] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 32'h00FF00FF, 7'd3, 7'd4, 8'h29};

    rst_n = 1'b0; load_en = 1'b0; byte_in = 8'h00; byte_strb = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(6);

    // Reset / IDLE state
    chk("rst_mem_we",    32'(mem_we), 32'd0);
    chk("rst_mem_addr",  32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_word_cnt",  32'(word_cnt), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_checksum",  32'(checksum), 32'd0);
    chk("idle_cpu_run",  32'(cpu_run), 32'd1);
    chk("idle_no_write", 32'(wr_addr.size()), 32'd0);

    // Table-driven single words in one load session
    load_en = 1'b1;
    idle(5);
    chk("load_cpu_run", 32'(cpu_run), 32'd0);
    for (int i = 0; i < 4; i++) begin
      base = wr_addr.size();
      send_byte(tbl[i].b0);
      send_byte(tbl[i].b1);
      send_byte(tbl[i].b2);
      send_byte(tbl[i].b3);
      chk($sformatf("vec%0d_nwrites", i), 32'(wr_addr.size() - base), 32'd1);
      if (wr_addr.size() > base) begin
        chk($sformatf("vec%0d_addr", i), 32'(wr_addr[base]), 32'(tbl[i].exp_addr));
        chk($sformatf("vec%0d_data", i), wr_data[base], tbl[i].exp_data);
      end
      chk($sformatf("vec%0d_cnt", i), 32'(word_cnt), 32'(tbl[i].exp_cnt));
      chk($sformatf("vec%0d_cpu_run", i), 32'(cpu_run), 32'd0);
      chk($sformatf("vec%0d_csum", i), 32'(checksum), CSUM_ON ? 32'(tbl[i].exp_csum) : 32'd0);
    end
    load_en = 1'b0;
    idle(6);
    chk("t1_load_done", 32'(load_done), 32'd1);
    chk("t1_cpu_run",   32'(cpu_run), 32'd1);
    chk("t1_word_cnt",  32'(word_cnt), 32'd4);

    // Eight words 0x00..0x1F, then drop load_en
    load_en = 1'b1;
    idle(6);
    chk("t2_restart_done", 32'(load_done), 32'd0);
    chk("t2_restart_cnt",  32'(word_cnt), 32'd0);
    base = wr_addr.size();
    for (int i = 0; i < 32; i++) send_byte(8'(i));
    load_en = 1'b0;
    idle(6);
    chk("t2_nwrites", 32'(wr_addr.size() - base), 32'd8);
    if (wr_addr.size() >= base + 8) begin
      for (int j = 0; j < 8; j++) begin
        expw = {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
        chk($sformatf("t2_addr%0d", j), 32'(wr_addr[base+j]), 32'(j));
        chk($sformatf("t2_data%0d", j), wr_data[base+j], expw);
      end
      chk("t2_word0", wr_data[base], 32'h03020100);
      chk("t2_word7", wr_data[base+7], 32'h1F1E1D1C);
    end
    chk("t2_load_done", 32'(load_done), 32'd1);
    chk("t2_cpu_run",   32'(cpu_run), 32'd1);
    chk("t2_word_cnt",  32'(word_cnt), 32'd8);
    chk("t2_mem_addr",  32'(mem_addr), 32'd8);

    // Full RAM plus 4 extra bytes: auto-finish, extra bytes ignored
    load_en = 1'b1;
    idle(6);
    base = wr_addr.size();
    for (int i = 0; i < 132; i++) send_byte(8'(i));
    chk("t3_nwrites", 32'(wr_addr.size() - base), 32'd32);
    if (wr_addr.size() >= base + 32) begin
      for (int j = 0; j < 32; j++)
        chk($sformatf("t3_addr%0d", j), 32'(wr_addr[base+j]), 32'(j));
      chk("t3_word31", wr_data[base+31], 32'h7F7E7D7C);
    end
    chk("t3_load_done", 32'(load_done), 32'd1);
    chk("t3_mem_addr",  32'(mem_addr), 32'd31);
    chk("t3_word_cnt",  32'(word_cnt), 32'd32);
    chk("t3_cpu_run",   32'(cpu_run), 32'd0);
    chk("t3_csum",      32'(checksum), CSUM_ON ? 32'h000000C0 : 32'd0);

    // Partial word then load_en drop, then restart
    load_en = 1'b0;
    idle(6);
    load_en = 1'b1;
    idle(6);
    base = wr_addr.size();
    send_byte(8'hFF);
    send_byte(8'h02);
    load_en = 1'b0;
    idle(6);
    chk("t4_no_write",  32'(wr_addr.size() - base), 32'd0);
    chk("t4_load_done", 32'(load_done), 32'd1);
    chk("t4_word_cnt",  32'(word_cnt), 32'd0);
    chk("t4_csum",      32'(checksum), CSUM_ON ? 32'h00000001 : 32'd0);
    load_en = 1'b1;
    idle(6);
    chk("t4_restart_done", 32'(load_done), 32'd0);
    chk("t4_restart_addr", 32'(mem_addr), 32'd0);
    chk("t4_restart_cnt",  32'(word_cnt), 32'd0);
    chk("t4_restart_csum", 32'(checksum), 32'd0);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    chk("t4_nwrites", 32'(wr_addr.size() - base), 32'd1);
    if (wr_addr.size() > base) begin
      chk("t4_addr", 32'(wr_addr[base]), 32'd0);
      chk("t4_data", wr_data[base], 32'h44332211);
    end

    // Asynchronous reset mid-word
    base = wr_addr.size();
    bv = 8'h55;
    for (int i = 0; i < 3; i++) begin
      send_byte(bv);
      bv = bv + 8'h11;
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_addr",  32'(mem_addr), 32'd0);
    chk("t5_rst_wdata", mem_wdata, 32'd0);
    chk("t5_rst_cnt",   32'(word_cnt), 32'd0);
    chk("t5_rst_we",    32'(mem_we), 32'd0);
    chk("t5_rst_done",  32'(load_done), 32'd0);
    chk("t5_rst_csum",  32'(checksum), 32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(6);
    chk("t5_no_write", 32'(wr_addr.size() - base), 32'd0);
    send_byte(8'h88);
    send_byte(8'h99);
    send_byte(8'hAA);
    send_byte(8'hBB);
    chk("t5_nwrites", 32'(wr_addr.size() - base), 32'd1);
    if (wr_addr.size() > base) begin
      chk("t5_addr", 32'(wr_addr[base]), 32'd0);
      chk("t5_data", wr_data[base], 32'hBBAA9988);
    end
    chk("t5_word_cnt", 32'(word_cnt), 32'd1);
    chk("t5_csum",     32'(checksum), CSUM_ON ? 32'h00000086 : 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
